// File: rtl/cudacore_pkg.sv
// Shared execute-stage types for the CUDA core:
// ALU opcodes, flag bundle and illegal-op fill pattern.
package cudacore_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SRL  = 4'd3,
    ALU_SRA  = 4'd4,
    ALU_AND  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_MIN  = 4'd10,
    ALU_MAX  = 4'd11,
    ALU_MINU = 4'd12,
    ALU_MAXU = 4'd13
  } alu_op_t;

  localparam logic [31:0] ALU_ILLEGAL_PATTERN = 32'hDEADDEAD;

  typedef struct packed {
    logic ovf;
    logic carry;
    logic neg;
    logic zero;
  } alu_flags_t;

endpackage

// File: rtl/int_alu_core.sv
// Combinational integer ALU: result, flags and illegal-op error.
// Width-parametrised so vector lanes can reuse it.
module int_alu_core
  import cudacore_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output alu_flags_t       flags,
  output logic             err
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [63:0] ILL_FILL = {2{ALU_ILLEGAL_PATTERN}};

  logic [SW-1:0] sh;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic lt_s;
  logic lt_u;
  logic msb_a;
  logic msb_b;

  always_comb begin
    sh    = b[SW-1:0];
    sum   = {1'b0, a} + {1'b0, b};
    diff  = {1'b0, a} - {1'b0, b};
    lt_s  = $signed(a) < $signed(b);
    lt_u  = diff[WIDTH];
    msb_a = a[WIDTH-1];
    msb_b = b[WIDTH-1];
    y     = '0;
    err   = 1'b0;
    flags = '0;
    case (op)
      ALU_ADD: begin
        y           = sum[WIDTH-1:0];
        flags.carry = sum[WIDTH];
        flags.ovf   = (msb_a == msb_b) && (y[WIDTH-1] != msb_a);
      end
      ALU_SUB: begin
        y           = diff[WIDTH-1:0];
        flags.carry = lt_u;
        flags.ovf   = (msb_a != msb_b) && (y[WIDTH-1] != msb_a);
      end
      ALU_SLL:  y = a << sh;
      ALU_SRL:  y = a >> sh;
      ALU_SRA:  y = $unsigned($signed(a) >>> sh);
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SLT:  y = {{(WIDTH-1){1'b0}}, lt_s};
      ALU_SLTU: y = {{(WIDTH-1){1'b0}}, lt_u};
      ALU_MIN:  y = lt_s ? a : b;
      ALU_MAX:  y = lt_s ? b : a;
      ALU_MINU: y = lt_u ? a : b;
      ALU_MAXU: y = lt_u ? b : a;
      default: begin
        y   = ILL_FILL[WIDTH-1:0];
        err = 1'b1;
      end
    endcase
    // illegal ops report no status at all
    if (!err) begin
      flags.zero = (y == '0);
      flags.neg  = y[WIDTH-1];
    end
  end

endmodule

// File: rtl/int_alu_pipe.sv
// Pipelined integer ALU with valid/ready handshake,
// bubble-collapsing stages and tag passthrough.
module int_alu_pipe
  import cudacore_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_t          in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [TAG_W-1:0] out_tag,
  output alu_flags_t       out_flags,
  output logic             out_err
);

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic [TAG_W-1:0] tag;
    alu_flags_t       flags;
    logic             err;
  } stage_t;

  logic [WIDTH-1:0] core_y;
  alu_flags_t       core_flags;
  logic             core_err;

  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] vld_d;
  stage_t             stg_q [LATENCY];
  stage_t             stg_d [LATENCY];
  logic [LATENCY-1:0] ld;

  int_alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op   (in_op),
    .a    (in_a),
    .b    (in_b),
    .y    (core_y),
    .flags(core_flags),
    .err  (core_err)
  );

  // stage k can load iff it or any later stage has room,
  // or the consumer drains the last stage this cycle
  always_comb begin
    logic room;
    room = out_ready;
    ld   = '0;
    for (int k = LATENCY - 1; k >= 0; k--) begin
      room  = room || !vld_q[k];
      ld[k] = room;
    end
  end

  always_comb begin
    vld_d = vld_q;
    stg_d = stg_q;
    if (ld[0]) begin
      vld_d[0] = in_valid;
      if (in_valid) begin
        stg_d[0] = stage_t'{
          y:     core_y,
          tag:   in_tag,
          flags: core_flags,
          err:   core_err
        };
      end
    end
    for (int k = 1; k < LATENCY; k++) begin
      if (ld[k]) begin
        vld_d[k] = vld_q[k-1];
        if (vld_q[k-1]) stg_d[k] = stg_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < LATENCY; k++) stg_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      stg_q <= stg_d;
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = vld_q[LATENCY-1];
  assign out_y     = stg_q[LATENCY-1].y;
  assign out_tag   = stg_q[LATENCY-1].tag;
  assign out_flags = stg_q[LATENCY-1].flags;
  assign out_err   = stg_q[LATENCY-1].err;

endmodule

// File: doc/int_alu_pipe.md
Name: int_alu_pipe

Overview:
- Parametrised, pipelined integer ALU for the CUDA core execute stage. It succeeds the single-cycle combinational integer ALU.
- Adds:
  - configurable data width and pipeline latency
  - valid/ready handshake with backpressure and bubble collapsing
  - tag passthrough, so the issue logic can match results to warp/register destinations
  - an extended opcode set: arithmetic shift, compares, min/max
  - status flags and an illegal-op error.

Parameters:
- WIDTH, 32, operand/result width in bits; legal values 8..64, power of two.
- LATENCY, 2, pipeline stages from input acceptance to output valid; legal values 1..4.
- TAG_W, 8, width of the opaque sideband tag carried with each operation.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  the block can accept an operation this cycle.
- in_op  in  4  opcode; type alu_op_t from cudacore_pkg.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_tag  in  TAG_W  sideband tag, returned unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_y  out  WIDTH  result.
- out_tag  out  TAG_W  tag of the result.
- out_flags  out  4  {ovf, carry, neg, zero}.
- out_err  out  1  the opcode was illegal.

Behaviour:
- Reset (rst=1 at a clock edge): all stage valid bits clear. out_valid=0, out_y=0, out_tag=0, out_flags=0, out_err=0. in_ready is 1 in the first cycle after reset. Reset mid-operation discards every in-flight op; no partial result is ever emitted.
- Handshake:
  - An input transfer occurs on an edge where in_valid && in_ready.
  - An output transfer occurs on an edge where out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_y/out_tag/out_flags/out_err hold stable.
  - in_ready is combinational from stage occupancy and out_ready; it never depends on in_valid.
- Pipeline:
  - LATENCY register stages S0..S(L-1).
  - The result is computed combinationally from the input and registered into S0. Later stages forward it.
  - Stage k advances when S(k+1) is empty or S(k+1) advances. The last stage advances when !out_valid || out_ready.
  - Bubbles collapse: with out_ready held 0, the pipe fills to LATENCY entries before in_ready falls.
  - in_ready = !S0.valid || S0 advances.
  - Unstalled latency is exactly LATENCY cycles: accepted at edge t, out_valid=1 after edge t+LATENCY-1. Throughput is one op/cycle.
- Arithmetic rules:
  - The shift amount is b[$clog2(WIDTH)-1:0]; higher bits of b are ignored.
  - ADD = a+b (mod 2^WIDTH). SUB = a-b.
  - SLL = a<<sh. SRL = logical a>>sh. SRA = arithmetic a>>>sh.
  - AND, OR, XOR are bitwise.
  - SLT = (signed a < signed b) ? 1 : 0, zero-extended. SLTU is the unsigned form.
  - MIN/MAX are signed. MINU/MAXU are unsigned.
  - Opcodes 14 and 15 are illegal: y = 0xDEADDEAD replicated/truncated to WIDTH, err=1, flags=0.
- Flags:
  - zero = (y==0). neg = y[WIDTH-1].
  - carry: the carry-out of an unsigned add for ADD; the borrow (a<b unsigned) for SUB; 0 otherwise.
  - ovf: signed overflow for ADD/SUB only; 0 otherwise.
- Simultaneous events: with the pipe full, out_ready=1 and in_valid=1 on the same edge, one op leaves and one enters (no bubble). Tags never reorder.

Decomposition:
- cudacore_pkg holds:
  - alu_op_t as a 4-bit enum: ADD=0, SUB=1, SLL=2, SRL=3, SRA=4, AND=5, OR=6, XOR=7, SLT=8, SLTU=9, MIN=10, MAX=11, MINU=12, MAXU=13
  - the constant ALU_ILLEGAL_PATTERN=32'hDEADDEAD
  - the typedef for the flags struct.
- One natural sub-module: int_alu_core. It is the purely combinational WIDTH-parametrised compute of y/flags/err, reused by future vector lanes.
- The pipeline/handshake logic stays in int_alu_pipe.

Test Plan:
- WIDTH=32, LATENCY=2, out_ready=1:
  - ADD 0x7FFFFFFF+1 -> y=0x80000000, ovf=1, neg=1, carry=0, out_valid two edges after acceptance.
  - SUB 0x00000003-5 -> y=0xFFFFFFFE, carry(borrow)=1, neg=1, ovf=0.
- SRA a=0x80000010, b=0x24 (sh=4) -> y=0xF8000001. SRL with the same inputs -> y=0x08000001. SLL a=1, b=31 -> y=0x80000000.
- Compares and min/max, a=0xFFFFFFFF, b=1: SLT -> 1, SLTU -> 0, MIN -> 0xFFFFFFFF, MAXU -> 0xFFFFFFFF. Op 15 -> y=0xDEADDEAD, err=1.
- Backpressure:
  - Hold out_ready=0 and stream tags 1,2,3: in_ready falls after 2 accepts.
  - Outputs stay stable on tag 1.
  - Then out_ready=1 with continuous input -> tags emerge 1,2,3,... with no gaps and no duplicates.
- Assert rst for one cycle with 2 ops in flight -> out_valid=0 next cycle, in_ready=1, and neither in-flight tag is ever emitted.
- WIDTH=8, LATENCY=1: ADD 0xFF+0x01 -> y=0x00, zero=1, carry=1, one-cycle latency. SLL by b=0x09 uses sh=1.
